// File: rtl/rr_arb16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package rr_arb16_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb16_if.sv
// Requester and output channel bundle for rr_arb16.
// The arbiter connects to the slave modport; producers/consumer use master.
interface rr_arb16_if #(
    parameter int WIDTH = 4
);
    import rr_arb16_pkg::*;

    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_rdy;
    logic                   out_vld;
    logic [WIDTH-1:0]       out_data;
    logic [ID_W-1:0]        out_id;
    logic                   out_rdy;

    modport slave (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_vld, out_data, out_id
    );

    modport master (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_vld, out_data, out_id
    );

endinterface

// File: rtl/rr_arb16_mux16.sv
// 16:1 data selector steering the granted requester's word to the output register.
module mux16 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [WIDTH-1:0] in8,
    input  logic [WIDTH-1:0] in9,
    input  logic [WIDTH-1:0] in10,
    input  logic [WIDTH-1:0] in11,
    input  logic [WIDTH-1:0] in12,
    input  logic [WIDTH-1:0] in13,
    input  logic [WIDTH-1:0] in14,
    input  logic [WIDTH-1:0] in15,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] dout
);

    // Pure selection; every sel value is covered so no default path is needed.
    always_comb begin
        dout = in0;
        case (sel)
            4'd0:  dout = in0;
            4'd1:  dout = in1;
            4'd2:  dout = in2;
            4'd3:  dout = in3;
            4'd4:  dout = in4;
            4'd5:  dout = in5;
            4'd6:  dout = in6;
            4'd7:  dout = in7;
            4'd8:  dout = in8;
            4'd9:  dout = in9;
            4'd10: dout = in10;
            4'd11: dout = in11;
            4'd12: dout = in12;
            4'd13: dout = in13;
            4'd14: dout = in14;
            4'd15: dout = in15;
            default: dout = in0;
        endcase
    end

endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter: 16 valid/ready requesters share one registered output.
// Optional handshake counter port grant_cnt is enabled by RR_ARB16_GRANT_CNT_EN.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | output register holds nothing (out_vld = 0)
// ST_FULL  | output register holds a word awaiting out_rdy
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb16_if.slave     bus
`ifdef RR_ARB16_GRANT_CNT_EN
    ,
    output logic [15:0]   grant_cnt
`endif
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic [2*N_REQ-1:0] vld_dbl;
    logic [N_REQ-1:0]   vld_rot;
    logic [ID_W-1:0]    off;
    logic               found;
    logic [ID_W-1:0]    gid;
    logic               gnt_any;
    logic               load;
    logic [N_REQ-1:0]   gnt_onehot;
    logic [WIDTH-1:0]   mux_out;

    // Rotate so the pointer position lands at bit 0; the doubled vector makes
    // the wrap-around a plain part-select.
    assign vld_dbl = {bus.req_vld, bus.req_vld};
    assign vld_rot = vld_dbl[{1'b0, ptr_q} +: N_REQ];

    // Find the first requester at or after the pointer in the rotated view.
    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && vld_rot[i]) begin
                off   = ID_W'(i);
                found = 1'b1;
            end
        end
    end

    // Unrotate: 4-bit addition wraps naturally back into requester space.
    assign gid        = ptr_q + off;
    assign gnt_any    = |bus.req_vld;
    assign load       = (state_q == ST_EMPTY) | bus.out_rdy;
    assign gnt_onehot = N_REQ'(1) << gid;

    // rst_n gating keeps req_rdy low for the whole reset window, since the
    // reset state alone (EMPTY) would otherwise advertise capacity.
    assign bus.req_rdy = (gnt_any && load && rst_n) ? gnt_onehot : '0;

    mux16 #(.WIDTH(WIDTH)) u_mux (
        .in0  (bus.req_data[ 0*WIDTH +: WIDTH]),
        .in1  (bus.req_data[ 1*WIDTH +: WIDTH]),
        .in2  (bus.req_data[ 2*WIDTH +: WIDTH]),
        .in3  (bus.req_data[ 3*WIDTH +: WIDTH]),
        .in4  (bus.req_data[ 4*WIDTH +: WIDTH]),
        .in5  (bus.req_data[ 5*WIDTH +: WIDTH]),
        .in6  (bus.req_data[ 6*WIDTH +: WIDTH]),
        .in7  (bus.req_data[ 7*WIDTH +: WIDTH]),
        .in8  (bus.req_data[ 8*WIDTH +: WIDTH]),
        .in9  (bus.req_data[ 9*WIDTH +: WIDTH]),
        .in10 (bus.req_data[10*WIDTH +: WIDTH]),
        .in11 (bus.req_data[11*WIDTH +: WIDTH]),
        .in12 (bus.req_data[12*WIDTH +: WIDTH]),
        .in13 (bus.req_data[13*WIDTH +: WIDTH]),
        .in14 (bus.req_data[14*WIDTH +: WIDTH]),
        .in15 (bus.req_data[15*WIDTH +: WIDTH]),
        .sel  (gid),
        .dout (mux_out)
    );

    // Next state: capture on grant, drain to EMPTY when idle, hold under backpressure.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (load) begin
            if (gnt_any) begin
                state_d = ST_FULL;
                data_d  = mux_out;
                id_d    = gid;
                ptr_d   = gid + 1'b1;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // Output register, pointer and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign bus.out_vld  = (state_q == ST_FULL);
    assign bus.out_data = data_q;
    assign bus.out_id   = id_q;

`ifdef RR_ARB16_GRANT_CNT_EN
    logic        live_q;
    logic [15:0] grant_cnt_q, grant_cnt_d;

    // live_q masks the first edge after reset release so that handshake is not counted.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (live_q && |(bus.req_vld & bus.req_rdy)) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    // Handshake counter, wraps at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q      <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            live_q      <= 1'b1;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule
